acc_round_sat: RTL and testbench
================================

Name: acc_round_sat

Overview:
- Downstream consumer of the pre-add/multiply/add DSP stage.
- Takes its signed (2*SIZEIN+1)-bit result stream and sums NTAPS consecutive samples into one frame result.
- Rounds and right-shifts the sum by SHIFT bits, saturates it to SIZEOUT bits, and hands it out through a 2-entry valid/ready output buffer.
- Completes the FIR/dot-product tap-sum path feeding the fabric.

Parameters:
- SIZEIN, 16: operand width of the upstream DSP stage; input width is 2*SIZEIN+1.
- NTAPS, 8: samples per frame, 2..256.
- SHIFT, 15: right shift applied after rounding, 0..2*SIZEIN.
- SIZEOUT, 16: output width, 2..2*SIZEIN+1.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- ce, in, 1: clock enable. When low, all state holds and in_ready is low.
- clr, in, 1: synchronous frame abort. Clears the accumulator and tap counter. Does not touch the output buffer.
- din, in, 2*SIZEIN+1: signed sample from the upstream DSP stage.
- din_valid, in, 1: din is valid this cycle.
- in_ready, out, 1: block accepts din this cycle.
- dout, out, SIZEOUT: signed rounded and saturated frame result.
- dout_valid, out, 1: head of the output buffer is valid.
- dout_ready, in, 1: downstream consumes the head.
- sat_flag, out, 1: sticky, set when any frame result saturated. Cleared only by reset or clr.

Behaviour:
- Reset (rst_n low, asynchronous): clear the accumulator, tap counter, round-stage register, buffer and sat_flag. Outputs go to dout=0, dout_valid=0, sat_flag=0, in_ready=0. Reset asserted mid-frame discards the partial sum.
- Accept: a sample is taken when din_valid && in_ready.
- Accumulator width: AW = 2*SIZEIN+1+clog2(NTAPS), signed. It never overflows internally.
- Tap counter: runs 0..NTAPS-1.
  - On accept with count < NTAPS-1: acc <= (count==0 ? din : acc+din), and count increments.
  - On accept with count == NTAPS-1 (last sample): sum = acc+din is loaded into the round stage (rs_valid=1), acc is cleared and count wraps to 0.
- Round stage, executed one cycle after the last sample when ce is high:
  - r = sum + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed in AW+1 bits. This is round-half-up.
  - q = r >>> SHIFT (arithmetic shift).
  - If q > 2^(SIZEOUT-1)-1, output the max value and set sat_flag. If q < -2^(SIZEOUT-1), output the min value and set sat_flag.
  - The result is written into the output buffer and rs_valid clears.
- Latency: last sample accepted at edge t; dout_valid is high after edge t+1 if the buffer was empty.
- Output buffer: 2-entry FIFO with count 0..2.
  - Head is presented on dout/dout_valid.
  - Pop when dout_valid && dout_ready. Pop is not gated by ce.
  - Push and pop in the same cycle keep the count unchanged.
  - dout holds its value while dout_valid && !dout_ready.
- Backpressure: in_ready = ce && rst_n && !(count_buf==2 || (count_buf==1 && rs_valid && !pop)).
  - This guarantees the round stage always has a slot, so no result is ever dropped.
  - Non-last samples are also stalled by this rule; that simplification is accepted.
- clr:
  - Takes priority over a same-cycle accept: the sample is discarded, acc=0, count=0.
  - A result already in the round stage or the buffer is still delivered.
  - sat_flag clears.
- ce low:
  - Accumulator, counter and round stage freeze.
  - The output buffer can still be popped.
  - sat_flag holds.
- din_valid while in_ready is low: the sample is ignored. Upstream must hold it.

Decomposition:
- Package acc_round_sat_pkg holds:
  - function clog2;
  - localparam-style helper functions sat_max(SIZEOUT) and sat_min(SIZEOUT);
  - the AW calculation.
- One sub-module, sat_fifo2: the 2-entry valid/ready output buffer with push, pop, count, head, rst_n.
- Accumulate, round and saturate logic stay in the top level.

Test Plan:
- Basic frame. Defaults (NTAPS=8, SHIFT=15, SIZEOUT=16); din=32768 for 8 consecutive cycles; dout_ready=1. Expected: sum=262144, dout=8, dout_valid one cycle after the 8th accept, sat_flag=0.
- Rounding. Frame with din = {16384, 0, 0, 0, 0, 0, 0, 0}. Expected: dout=1 (0.5 rounds up). Frame with {-16384, 0, …}: dout=0. Frame with {-16385, 0, …}: dout=-1.
- Saturation. Frame with din=2^31 (max positive 33-bit magnitude region) ×8. Expected: dout=32767, sat_flag=1 and stays set. Next frame of zeros: dout=0, sat_flag still 1.
- Backpressure. dout_ready=0; stream three frames back-to-back. Expected: two results buffered; in_ready drops before the third frame's last sample completes; no result lost. Then raise dout_ready and check the three results pop in order.
- clr mid-frame. Accept 5 samples, assert clr alongside a 6th valid sample, then send 8 samples of 32768. Expected: one result dout=8, and sat_flag=0 afterwards.
- Async reset mid-operation. Drop rst_n between clock edges while dout_valid=1 and a partial frame is in progress. Expected: dout_valid=0, dout=0 and in_ready=0 immediately. After release, a fresh 8-sample frame gives the correct result.

Source files
------------

// File: rtl/acc_round_sat_pkg.sv
// Shared helpers for the tap-sum round/saturate block:
// width calculation and output saturation limits.
package acc_round_sat_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int acc_width(input int sizein, input int ntaps);
        return 2 * sizein + 1 + clog2(ntaps);
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_fifo2.sv
// Two-entry valid/ready output buffer; head is always presented on dout.
// Caller never pushes into a full buffer unless it pops in the same cycle.
module sat_fifo2
    import acc_round_sat_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] head;
    logic [W-1:0] tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        head  <= din;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        tail  <= din;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= din;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
                default: count <= 2'd0;
            endcase
        end
    end

    assign dout  = head;
    assign valid = (count != 2'd0);

endmodule

// File: rtl/acc_round_sat.sv
// Sums NTAPS samples per frame, rounds half-up, shifts by SHIFT and
// saturates to SIZEOUT bits, delivering results through a 2-entry buffer.
module acc_round_sat
    import acc_round_sat_pkg::*;
#(
    parameter int SIZEIN  = 16,
    parameter int NTAPS   = 8,
    parameter int SHIFT   = 15,
    parameter int SIZEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        clr,
    input  logic signed [2*SIZEIN:0]    din,
    input  logic                        din_valid,
    output logic                        in_ready,
    output logic signed [SIZEOUT-1:0]   dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        sat_flag
);

    localparam int IW = 2 * SIZEIN + 1;
    localparam int AW = acc_width(SIZEIN, NTAPS);
    localparam int CW = clog2(NTAPS);

    localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);
    localparam logic signed [AW:0] RND  = (AW+1)'((64'd1 << SHIFT) >> 1);
    localparam logic signed [AW:0] QMAX = (AW+1)'(sat_max(SIZEOUT));
    localparam logic signed [AW:0] QMIN = (AW+1)'(sat_min(SIZEOUT));

    logic signed [AW-1:0]      acc;
    logic signed [AW-1:0]      rs_sum;
    logic signed [AW-1:0]      din_ext;
    logic signed [AW-1:0]      sum;
    logic [CW-1:0]             tap;
    logic                      rs_valid;
    logic                      sat_q;
    logic                      accept;
    logic                      last;
    logic                      push;
    logic                      pop;
    logic                      fvalid;
    logic [1:0]                fcount;
    logic signed [AW:0]        r;
    logic signed [AW:0]        q;
    logic signed [SIZEOUT-1:0] res;
    logic                      res_sat;

    // Keep a slot free for whatever the round stage will push next cycle.
    assign pop      = fvalid && dout_ready;
    assign in_ready = ce && rst_n &&
                      !(fcount == 2'd2 ||
                        (fcount == 2'd1 && rs_valid && !pop));

    assign accept  = din_valid && in_ready && !clr;
    assign last    = accept && (tap == LAST);
    assign din_ext = {{(AW-IW){din[IW-1]}}, din};
    assign sum     = acc + din_ext;
    assign push    = rs_valid && ce;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            tap      <= '0;
            rs_sum   <= '0;
            rs_valid <= 1'b0;
        end else if (ce) begin
            if (clr) begin
                acc <= '0;
                tap <= '0;
            end else if (accept) begin
                if (tap == LAST) begin
                    rs_sum <= sum;
                    acc    <= '0;
                    tap    <= '0;
                end else begin
                    acc <= (tap == '0) ? din_ext : sum;
                    tap <= tap + CW'(1);
                end
            end
            rs_valid <= last;
        end
    end

    always_comb begin
        r       = {rs_sum[AW-1], rs_sum} + RND;
        q       = r >>> SHIFT;
        res     = q[SIZEOUT-1:0];
        res_sat = 1'b0;
        if (q > QMAX) begin
            res     = QMAX[SIZEOUT-1:0];
            res_sat = 1'b1;
        end else if (q < QMIN) begin
            res     = QMIN[SIZEOUT-1:0];
            res_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (ce) begin
            if (clr) begin
                sat_q <= 1'b0;
            end else if (push && res_sat) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign sat_flag   = sat_q;
    assign dout_valid = fvalid;

    sat_fifo2 #(
        .W(SIZEOUT)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (res),
        .dout  (dout),
        .valid (fvalid),
        .count (fcount)
    );

endmodule

// File: tb/tb_acc_round_sat.sv
// Directed and randomized checks of acc_round_sat against a
// frame-level arithmetic reference model.
module tb_acc_round_sat;

    localparam int SIZEIN  = 16;
    localparam int NTAPS   = 8;
    localparam int SHIFT   = 15;
    localparam int SIZEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      ce = 1'b1;
    logic                      clr = 1'b0;
    logic signed [2*SIZEIN:0]  din = '0;
    logic                      din_valid = 1'b0;
    logic                      in_ready;
    logic signed [SIZEOUT-1:0] dout;
    logic                      dout_valid;
    logic                      dout_ready = 1'b1;
    logic                      sat_flag;

    int checks = 0;
    int errors = 0;
    bit rnd = 1'b0;

    logic signed [SIZEOUT-1:0] exp_q[$];
    logic signed [SIZEOUT-1:0] e;
    longint frame_sum = 0;
    int     frame_n = 0;
    bit     sat_model = 1'b0;

    acc_round_sat #(
        .SIZEIN (SIZEIN),
        .NTAPS  (NTAPS),
        .SHIFT  (SHIFT),
        .SIZEOUT(SIZEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .clr       (clr),
        .din       (din),
        .din_valid (din_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    // Frame result: floor((sum + half) / 2^SHIFT), clamped to SIZEOUT bits.
    function automatic void model_frame(input longint s);
        longint half;
        longint q;
        longint hi;
        longint lo;
        half = (longint'(1) << SHIFT) / 2;
        q    = (s + half) >>> SHIFT;
        hi   = (longint'(1) << (SIZEOUT - 1)) - 1;
        lo   = -(longint'(1) << (SIZEOUT - 1));
        if (q > hi) begin
            q = hi;
            sat_model = 1'b1;
        end else if (q < lo) begin
            q = lo;
            sat_model = 1'b1;
        end
        exp_q.push_back(SIZEOUT'(q));
    endfunction

    function automatic void model_accept(input logic signed [2*SIZEIN:0] v);
        frame_sum += longint'(v);
        frame_n++;
        if (frame_n == NTAPS) begin
            model_frame(frame_sum);
            frame_sum = 0;
            frame_n   = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            dout_ready = 1'($urandom_range(0, 1));
            ce = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input logic signed [2*SIZEIN:0] v);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        din = v;
        din_valid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        din_valid = 1'b0;
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL send_timeout got in_ready=0 expected accept of %0d", v);
        end
        if (ok) model_accept(v);
    endtask

    task automatic send_frame(input logic signed [2*SIZEIN:0] v);
        for (int i = 0; i < NTAPS; i++) send(v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Every popped head is compared with the model's next result.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_pop got %0d expected no result", dout);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                assert (dout === e) else begin
                    errors++;
                    $error("FAIL dout got %0d expected %0d", dout, e);
                end
            end
        end
    end

    initial begin
        logic signed [2*SIZEIN:0] v;
        logic [31:0] lo;
        bit hi;
        int s;

        // reset state
        #2 rst_n = 1'b0;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_in_ready", in_ready, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 1);

        // basic frame and latency
        dout_ready = 1'b1;
        send_frame(33'sd32768);
        chk("lat_not_yet", dout_valid, 0);
        tick();
        chk("lat_valid", dout_valid, 1);
        chk("basic_dout", dout, 8);
        drain();
        chk("basic_sat", sat_flag, 0);

        // rounding
        send(33'sd16384);
        for (int i = 1; i < NTAPS; i++) send(33'sd0);
        send(-33'sd16384);
        for (int i = 1; i < NTAPS; i++) send(33'sd0);
        send(-33'sd16385);
        for (int i = 1; i < NTAPS; i++) send(33'sd0);
        drain();
        chk("round_sat", sat_flag, 0);

        // saturation, sticky flag
        send_frame(33'sd2147483648);
        drain();
        chk("sat_set", sat_flag, 1);
        send_frame(33'sd0);
        drain();
        chk("sat_sticky", sat_flag, 1);
        send_frame(-33'sd2147483648);
        drain();
        chk("sat_neg", sat_flag, sat_model);

        // backpressure: two results buffered, third frame stalls
        dout_ready = 1'b0;
        send_frame(33'sd32768);
        send_frame(33'sd65536);
        tick();
        tick();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_valid", dout_valid, 1);
        chk("bp_head", dout, exp_q[0]);
        tick();
        tick();
        chk("bp_hold", dout, exp_q[0]);
        chk("bp_depth", exp_q.size(), 2);
        dout_ready = 1'b1;
        send_frame(-33'sd32768);
        drain();

        // clr mid-frame discards partial sum and clears sat_flag
        for (int i = 0; i < 5; i++) send(33'sd1000);
        din = 33'sd7;
        din_valid = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        din_valid = 1'b0;
        frame_sum = 0;
        frame_n = 0;
        sat_model = 1'b0;
        send_frame(33'sd32768);
        drain();
        chk("clr_sat", sat_flag, 0);

        // async reset mid-operation
        dout_ready = 1'b0;
        send_frame(33'sd32768);
        for (int i = 0; i < 3; i++) send(33'sd1000);
        tick();
        tick();
        chk("pre_rst_valid", dout_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
        chk("arst_in_ready", in_ready, 0);
        exp_q.delete();
        frame_sum = 0;
        frame_n = 0;
        sat_model = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        dout_ready = 1'b1;
        send_frame(33'sd32768);
        drain();

        // randomized frames with random ce and backpressure
        rnd = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NTAPS; i++) begin
                if (f % 2 == 1) begin
                    lo = $urandom;
                    hi = 1'($urandom_range(0, 1));
                    v = {hi, lo};
                end else begin
                    s = int'($urandom_range(0, 2000000)) - 1000000;
                    v = 33'(s);
                end
                if ($urandom_range(0, 3) == 0) tick();
                send(v);
            end
        end
        rnd = 1'b0;
        ce = 1'b1;
        dout_ready = 1'b1;
        drain();
        chk("rand_sat", sat_flag, sat_model);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
